// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per clock, LSB slice first.
// Define ADDER_SATURATE_EN to clamp sum on signed overflow.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, acc_q;
  logic              carry_q, a_msb_q, b_msb_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carryout_q, overflow_q, zero_q;

  logic [CHUNK:0]    slice_res;
  logic [WIDTH-1:0]  acc_d, sum_d;
  logic              last_slice, msb_cin, ovf;

  assign last_slice = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Slices shift in at the top so that after N steps they sit in LSB-first order.
  always_comb begin
    slice_res = {1'b0, a_sh_q[CHUNK-1:0]} + {1'b0, b_sh_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    acc_d     = (acc_q >> CHUNK) | (WIDTH'(slice_res[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin   = acc_d[WIDTH-1] ^ a_msb_q ^ b_msb_q;
    ovf       = msb_cin ^ slice_res[CHUNK];
`ifdef ADDER_SATURATE_EN
    // On overflow both operands share a sign, which is the sign of the true result.
    sum_d     = ovf ? {a_msb_q, {(WIDTH-1){~a_msb_q}}} : acc_d;
`else
    sum_d     = acc_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state_q == StIdle && start) begin
      a_sh_q  <= a;
      b_sh_q  <= b ^ {WIDTH{sub}};
      carry_q <= sub;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1] ^ sub;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_sh_q  <= a_sh_q >> CHUNK;
      b_sh_q  <= b_sh_q >> CHUNK;
      carry_q <= slice_res[CHUNK];
      acc_q   <= acc_d;
      cnt_q   <= cnt_q + CntW'(1);
      if (last_slice) begin
        sum_q      <= sum_d;
        carryout_q <= slice_res[CHUNK];
        overflow_q <= ovf;
        zero_q     <= (acc_d == '0);
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder (WIDTH=8, CHUNK=2) with a result scoreboard.
module tb_multicycle_adder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHUNK = 2;
  localparam int unsigned N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [7:0] sum;
    logic       carryout;
    logic       overflow;
    logic       zero;
  } res_t;

  logic       clk = 1'b0;
  logic       reset, start, sub;
  logic [7:0] a, b;
  logic       busy, done, carryout, overflow, zero;
  logic [7:0] sum;

  res_t exp_q[$];
  res_t prev;
  int   tests = 0;
  int   fails = 0;

  multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [8:0] t;
    logic [7:0] yy;
    res_t       r;
    yy         = s ? ~y : y;
    t          = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    r.sum      = t[7:0];
    r.carryout = t[8];
    r.overflow = (x[7] == yy[7]) && (t[7] != x[7]);
    r.zero     = (t[7:0] == 8'd0);
`ifdef ADDER_SATURATE_EN
    if (r.overflow) r.sum = x[7] ? 8'h80 : 8'h7F;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, e.sum});
    chk({tag, "_cout"}, {31'd0, carryout}, {31'd0, e.carryout});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.overflow});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    chk({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_res(tag, e);
      prev = e;
    end
  endtask

  // One full operation: accept, outputs hold during RUN, latency, result, return to IDLE.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s);
    int lat;
    a = x; b = y; sub = s; start = 1'b1;
    exp_q.push_back(model(x, y, s));
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      chk_res({tag, "_hold"}, prev);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, N);
    if (done) pop_check(tag);
    tick();
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    prev  = '0;
    reset = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_res("rst", '0);

    run_op("ovf_add", 8'h7F, 8'h01, 1'b0);
    run_op("sub_zero", 8'h05, 8'h05, 1'b1);
    run_op("wrap_zero", 8'hFF, 8'h01, 1'b0);
    run_op("ovf_sub", 8'h80, 8'h01, 1'b1);

    // Abort in the 2nd RUN cycle.
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk_res("abort", '0);
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end

    run_op("after_abort", 8'h12, 8'h34, 1'b0);
    run_op("carry_chain", 8'h0F, 8'h01, 1'b0);

    // Start held high: one op every N+2 cycles, operand changes in RUN ignored.
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(a, b, sub));
    tick();
    for (int k = 0; k <= 17; k++) begin
      if (k == 2) begin
        a = 8'h55; b = 8'h22; sub = 1'b0;
        exp_q.push_back(model(a, b, sub));
      end
      if (k == 8) begin
        a = 8'h01; b = 8'h01; sub = 1'b1;
        exp_q.push_back(model(a, b, sub));
      end
      if (k == 12) begin
        start = 1'b0; a = 8'hAA; b = 8'h11;
      end
      chk("held_done", {31'd0, done}, (k % 6 == 4) ? 32'd1 : 32'd0);
      chk("held_busy", {31'd0, busy}, (k % 6 != 5) ? 32'd1 : 32'd0);
      if (done) pop_check("held");
      tick();
    end
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; number of slices N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  first operand, 2's complement; sampled with start.
REQ-008 b  input  WIDTH  second operand, 2's complement; sampled with start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 sum  output  WIDTH  result.
REQ-012 carryout  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-013 overflow  output  1  signed overflow.
REQ-014 zero  output  1  high when the unsaturated result is all zeros.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; the reset state is IDLE.
REQ-016 IDLE with start=1 at an edge SHALL register a, b^{WIDTH{sub}} and the initial carry (= sub), clear the slice counter, and move to RUN.
REQ-017 Each RUN edge SHALL add one CHUNK slice, LSB slice first, using the registered carry; it SHALL store the slice sum and the carry, and increment the counter.
REQ-018 After the Nth slice edge the FSM SHALL move to DONE and update sum/carryout/overflow/zero at that same edge; done SHALL be high for exactly that one cycle.
REQ-019 Latency: start sampled at edge E0 gives done=1 in the cycle following edge E0+N.
REQ-020 DONE SHALL return to IDLE at the next edge unconditionally; start in RUN or DONE SHALL be ignored, not queued.
REQ-021 overflow SHALL equal (carry into MSB) XOR carryout.
REQ-022 sum, carryout, overflow and zero SHALL hold their values from the last DONE until the next DONE; they SHALL NOT change during RUN (slice results go to an internal register).
REQ-023 Arithmetic is modulo 2^WIDTH, and the carry chain SHALL be continuous across slice boundaries.
REQ-024 With N=1 the block SHALL still take one RUN cycle.

Reset
REQ-025 With reset=1 at an edge: state = IDLE, counter = 0, and busy, done, sum, carryout, overflow and zero = 0; this takes priority over start.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no done SHALL follow.

Configuration
REQ-027 Macro ADDER_SATURATE_EN: when defined, sum SHALL clamp on overflow to the most positive value (0 followed by ones) if the true result is positive, or to the most negative value (1 followed by zeros) if it is negative; carryout, overflow and zero SHALL be unaffected.
REQ-028 When ADDER_SATURATE_EN is not defined, sum SHALL be the wrapped result and the saturation logic SHALL be absent.

Verification (WIDTH=8, CHUNK=2, N=4)
REQ-029 a=0x7F, b=0x01, sub=0 -> done one cycle after edge E0+4; sum=0x80 (0x7F with the macro), carryout=0, overflow=1, zero=0.
REQ-030 a=0x05, b=0x05, sub=1 -> sum=0x00, zero=1, carryout=1, overflow=0; a=0xFF, b=0x01, sub=0 -> sum=0x00, carryout=1, overflow=0, zero=1.
REQ-031 a=0x80, b=0x01, sub=1 -> sum=0x7F (0x80 with the macro), carryout=1, overflow=1.
REQ-032 Start held high continuously -> accepted in IDLE only; one operation every N+2 cycles; done pulses are exactly one cycle wide; the operand change during RUN has no effect.
REQ-033 Reset pulsed in the 2nd RUN cycle -> no done; all outputs 0; busy=0 next cycle; a new start is then accepted normally.
REQ-034 Carry across slices: a=0x0F, b=0x01, sub=0 -> sum=0x10, carryout=0, overflow=0; the previous outputs stay stable until done.
